// File: rtl/axi_lite_write_slave_fifo.sv
`timescale 1ns/1ps
// AXI4-Lite write slave: AW/W captured into holding slots, each completed write pushed into an output FIFO.
// Optional address-window decode (SLVERR, no push) enabled by defining AXIW_ADDR_DECODE_ERR_EN.
module axi_lite_write_slave_fifo #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] ADDR_RANGE = ADDR_W'(32'h0000_1000)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          AWVALID,
    input  logic [ADDR_W-1:0]             AWADDR,
    output logic                          AWREADY,
    input  logic                          WVALID,
    input  logic [DATA_W-1:0]             WDATA,
    input  logic [DATA_W/8-1:0]           WSTRB,
    output logic                          WREADY,
    output logic                          BVALID,
    output logic [1:0]                    BRESP,
    input  logic                          BREADY,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [DATA_W-1:0]             out_data,
    output logic [DATA_W/8-1:0]           out_strb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {COLLECT, PUSH, RESP} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } entry_t;

    state_e              state_q, state_d;
    logic                aw_full_q, aw_full_d;
    logic                w_full_q, w_full_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                out_valid_q, out_valid_d;
    logic                push_c;
    logic                pop_c;
    entry_t              mem_q [FIFO_DEPTH];

`ifdef AXIW_ADDR_DECODE_ERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    logic [ADDR_W:0] win_lo_c, win_hi_c;
    logic            in_window_c;
    // Compare one bit wider so BASE_ADDR+ADDR_RANGE cannot wrap.
    assign win_lo_c    = {1'b0, BASE_ADDR};
    assign win_hi_c    = win_lo_c + {1'b0, ADDR_RANGE};
    assign in_window_c = ({1'b0, aw_addr_q} >= win_lo_c) && ({1'b0, aw_addr_q} < win_hi_c);
`else
    logic unused_params_c;
    assign unused_params_c = ^{BASE_ADDR, ADDR_RANGE};
`endif

    // Next-state: slot capture, write FSM, FIFO pointers and level
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push_c    = 1'b0;
        pop_c     = out_valid_q && out_ready;

        if (awready_q && AWVALID) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end
        if (wready_q && WVALID) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        case (state_q)
            COLLECT: begin
                if (aw_full_q && w_full_q) state_d = PUSH;
            end
            PUSH: begin
`ifdef AXIW_ADDR_DECODE_ERR_EN
                if (!in_window_c) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_SLVERR;
                    state_d   = RESP;
                end else
`endif
                if (level_q < LVL_W'(FIFO_DEPTH)) begin
                    push_c    = 1'b1;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        level_d     = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        out_valid_d = (level_d != '0);
        awready_d   = !aw_full_d && !bvalid_d;
        wready_d    = !w_full_d && !bvalid_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= COLLECT;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Entry storage; contents are meaningless unless counted by level_q
    always_ff @(posedge ACLK) begin
        if (push_c) mem_q[wr_ptr_q] <= '{addr: aw_addr_q, data: w_data_q, strb: w_strb_q};
    end

    assign AWREADY    = awready_q;
    assign WREADY     = wready_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = mem_q[rd_ptr_q].addr;
    assign out_data   = mem_q[rd_ptr_q].data;
    assign out_strb   = mem_q[rd_ptr_q].strb;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_axi_lite_write_slave_fifo.sv
`timescale 1ns/1ps
// Randomized self-checking bench for axi_lite_write_slave_fifo against a queue-based reference model.
module tb_axi_lite_write_slave_fifo;

    localparam int unsigned DEPTH = 4;
`ifdef AXIW_ADDR_DECODE_ERR_EN
    localparam bit DECODE = 1'b1;
`else
    localparam bit DECODE = 1'b0;
`endif

    logic        ACLK, ARESETN;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;
    logic        out_valid, out_ready;
    logic [31:0] out_addr, out_data;
    logic [3:0]  out_strb;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t model_q[$];
    int   total = 0;
    int   bad   = 0;

    axi_lite_write_slave_fifo #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(32'h0000_0000), .ADDR_RANGE(32'h0000_1000)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_strb(out_strb),
        .fifo_level(fifo_level)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected response: window is [0, 0x1000) when decode is compiled in
    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (DECODE && a >= 32'h1000) ? 2'b10 : 2'b00;
    endfunction

    // Scoreboard: every pop must return the oldest outstanding OKAY write
    initial forever begin
        @(negedge ACLK);
        #2;
        if (ARESETN && out_valid && out_ready) begin
            total++;
            if (model_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got addr=%h data=%h exp=empty", out_addr, out_data);
            end else begin
                if (out_addr !== model_q[0].addr || out_data !== model_q[0].data || out_strb !== model_q[0].strb) begin
                    bad++;
                    $display("FAIL pop_entry got=%h/%h/%h exp=%h/%h/%h", out_addr, out_data, out_strb,
                             model_q[0].addr, model_q[0].data, model_q[0].strb);
                end
                void'(model_q.pop_front());
            end
        end
    end

    // Drive AW and W with independent start delays; returns at a negedge after both handshakes
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, output bit ok);
        bit aw_ok, w_ok;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        fork
            begin
                repeat (awd) @(negedge ACLK);
                AWVALID = 1'b1;
                AWADDR  = a;
                for (int i = 0; i < 400; i++) begin
                    if (AWREADY) begin aw_ok = 1'b1; @(negedge ACLK); break; end
                    @(negedge ACLK);
                end
                AWVALID = 1'b0;
                AWADDR  = $urandom;
            end
            begin
                repeat (wd) @(negedge ACLK);
                WVALID = 1'b1;
                WDATA  = d;
                WSTRB  = s;
                for (int j = 0; j < 400; j++) begin
                    if (WREADY) begin w_ok = 1'b1; @(negedge ACLK); break; end
                    @(negedge ACLK);
                end
                WVALID = 1'b0;
                WDATA  = $urandom;
                WSTRB  = 4'($urandom);
            end
        join
        ok = aw_ok && w_ok;
    endtask

    // Wait for BVALID, then accept it after bdly cycles
    task automatic wait_b(input int bdly, output logic [1:0] resp, output bit ok);
        ok     = 1'b0;
        BREADY = (bdly == 0);
        for (int i = 0; i < 400; i++) begin
            if (BVALID) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        resp = BRESP;
        repeat (bdly) @(negedge ACLK);
        BREADY = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK);
            if (fifo_level == 0) break;
        end
        out_ready = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1; out_ready = 1'b0;
        AWADDR = $urandom; WDATA = $urandom; WSTRB = 4'($urandom);
        @(negedge ACLK);
        total++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || BRESP !== 2'b00 ||
            out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL reset_values got aw=%b w=%b bv=%b br=%b ov=%b lvl=%0d exp 0 0 0 00 0 0",
                     AWREADY, WREADY, BVALID, BRESP, out_valid, fifo_level);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        total++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got aw=%b w=%b exp 1 1", AWREADY, WREADY);
        end
    endtask

    task automatic test_same_cycle();
        out_ready = 1'b0; BREADY = 1'b1;
        model_q.push_back('{addr: 32'h10, data: 32'hDEAD_BEEF, strb: 4'hF});
        AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        total++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
            bad++;
            $display("FAIL sc_ready_drop got aw=%b w=%b exp 0 0", AWREADY, WREADY);
        end
        @(negedge ACLK);
        total++;
        if (BVALID !== 1'b0) begin
            bad++;
            $display("FAIL sc_push_cycle got bvalid=%b exp 0", BVALID);
        end
        @(negedge ACLK);
        total++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00 || out_valid !== 1'b1 || fifo_level !== 3'd1 ||
            out_addr !== 32'h10 || out_data !== 32'hDEAD_BEEF || out_strb !== 4'hF) begin
            bad++;
            $display("FAIL sc_resp got bv=%b br=%b ov=%b lvl=%0d %h/%h/%h exp 1 00 1 1 10/deadbeef/f",
                     BVALID, BRESP, out_valid, fifo_level, out_addr, out_data, out_strb);
        end
        @(negedge ACLK);
        total++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            bad++;
            $display("FAIL sc_b_done got bv=%b aw=%b w=%b exp 0 1 1", BVALID, AWREADY, WREADY);
        end
        drain();
        total++;
        if (fifo_level !== 3'd0 || model_q.size() != 0) begin
            bad++;
            $display("FAIL sc_drain got lvl=%0d model=%0d exp 0 0", fifo_level, model_q.size());
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r;
        bit ok;
        out_ready = 1'b0;
        model_q.push_back('{addr: 32'h20, data: 32'h1234, strb: 4'hF});
        WVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'hF;
        @(negedge ACLK);
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
                bad++;
                $display("FAIL wa_wait%0d got w=%b bv=%b aw=%b exp 0 0 1", i, WREADY, BVALID, AWREADY);
            end
            @(negedge ACLK);
        end
        AWVALID = 1'b1; AWADDR = 32'h20;
        @(negedge ACLK);
        AWVALID = 1'b0;
        wait_b(0, r, ok);
        total++;
        if (!ok || r !== 2'b00 || fifo_level !== 3'd1 || out_addr !== 32'h20 || out_data !== 32'h1234) begin
            bad++;
            $display("FAIL wa_result got ok=%0d br=%b lvl=%0d %h/%h exp 1 00 1 20/1234",
                     ok, r, fifo_level, out_addr, out_data);
        end
        drain();
    endtask

    task automatic test_fifo_full();
        logic [1:0] r;
        bit ok;
        int seen;
        ent_t e;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            e = '{addr: 32'($urandom_range(0, 1023)) << 2, data: $urandom, strb: 4'($urandom)};
            model_q.push_back(e);
            send_aw_w(e.addr, e.data, e.strb, 0, i % 2, ok);
            if (i < DEPTH) begin
                wait_b(0, r, ok);
                total++;
                if (!ok || r !== 2'b00) begin
                    bad++;
                    $display("FAIL full_fill%0d got ok=%0d br=%b exp 1 00", i, ok, r);
                end
            end
        end
        seen = 0;
        repeat (10) begin
            @(negedge ACLK);
            if (BVALID) seen++;
        end
        total++;
        if (seen != 0 || fifo_level !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL full_stall got bvalid_cycles=%0d lvl=%0d exp 0 %0d", seen, fifo_level, DEPTH);
        end
        out_ready = 1'b1;
        @(negedge ACLK);
        out_ready = 1'b0;
        wait_b(0, r, ok);
        total++;
        if (!ok || r !== 2'b00 || fifo_level !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL full_release got ok=%0d br=%b lvl=%0d exp 1 00 %0d", ok, r, fifo_level, DEPTH);
        end
        drain();
        total++;
        if (fifo_level !== 3'd0 || model_q.size() != 0) begin
            bad++;
            $display("FAIL full_drain got lvl=%0d model=%0d exp 0 0", fifo_level, model_q.size());
        end
    endtask

    task automatic test_b_stall();
        bit ok;
        out_ready = 1'b0; BREADY = 1'b0;
        model_q.push_back('{addr: 32'h30, data: 32'hCAFE_0001, strb: 4'h3});
        send_aw_w(32'h30, 32'hCAFE_0001, 4'h3, 0, 0, ok);
        for (int i = 0; i < 20; i++) begin
            if (BVALID) break;
            @(negedge ACLK);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                bad++;
                $display("FAIL bstall%0d got bv=%b br=%b aw=%b w=%b exp 1 00 0 0", i, BVALID, BRESP, AWREADY, WREADY);
            end
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        total++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            bad++;
            $display("FAIL bstall_release got bv=%b aw=%b w=%b exp 0 1 1", BVALID, AWREADY, WREADY);
        end
        drain();
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                logic [1:0] r, er;
                bit ok;
                ent_t e;
                for (int i = 0; i < 24; i++) begin
                    e.addr = 32'($urandom_range(0, 8191)) & 32'hFFFF_FFFC;
                    e.data = $urandom;
                    e.strb = (i % 6 == 0) ? 4'h0 : 4'($urandom);
                    er = exp_resp(e.addr);
                    if (er == 2'b00) model_q.push_back(e);
                    send_aw_w(e.addr, e.data, e.strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ok);
                    wait_b(int'($urandom_range(0, 2)), r, ok);
                    total++;
                    if (!ok || r !== er) begin
                        bad++;
                        $display("FAIL rand_resp%0d got ok=%0d br=%b exp 1 %b", i, ok, r, er);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge ACLK);
                    out_ready = 1'($urandom);
                end
                out_ready = 1'b0;
            end
        join
        drain();
        total++;
        if (fifo_level !== 3'd0 || model_q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain got lvl=%0d model=%0d exp 0 0", fifo_level, model_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_q.push_back('{addr: 32'(i * 4 + 'h100), data: $urandom, strb: 4'hF});
            send_aw_w(model_q[i].addr, model_q[i].data, 4'hF, 0, 0, ok);
            if (i < 2) wait_b(0, r, ok);
        end
        BREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (BVALID) break;
            @(negedge ACLK);
        end
        total++;
        if (BVALID !== 1'b1 || fifo_level !== 3'd3) begin
            bad++;
            $display("FAIL rm_setup got bv=%b lvl=%0d exp 1 3", BVALID, fifo_level);
        end
        ARESETN = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || BVALID !== 1'b0 || AWREADY !== 1'b0) begin
            bad++;
            $display("FAIL rm_async got ov=%b lvl=%0d bv=%b aw=%b exp 0 0 0 0", out_valid, fifo_level, BVALID, AWREADY);
        end
        model_q.delete();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        total++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rm_release got aw=%b w=%b ov=%b exp 1 1 0", AWREADY, WREADY, out_valid);
        end
        model_q.push_back('{addr: 32'h40, data: 32'h0BAD_F00D, strb: 4'hC});
        send_aw_w(32'h40, 32'h0BAD_F00D, 4'hC, 1, 0, ok);
        wait_b(0, r, ok);
        total++;
        if (!ok || r !== 2'b00 || fifo_level !== 3'd1 || out_addr !== 32'h40 || out_strb !== 4'hC) begin
            bad++;
            $display("FAIL rm_write got ok=%0d br=%b lvl=%0d addr=%h strb=%h exp 1 00 1 40 c",
                     ok, r, fifo_level, out_addr, out_strb);
        end
        drain();
    endtask

`ifdef AXIW_ADDR_DECODE_ERR_EN
    task automatic test_decode();
        logic [1:0] r;
        bit ok;
        out_ready = 1'b0;
        send_aw_w(32'h1000, 32'h1111_1111, 4'hF, 0, 0, ok);
        wait_b(0, r, ok);
        total++;
        if (!ok || r !== 2'b10 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL dec_out got ok=%0d br=%b lvl=%0d exp 1 10 0", ok, r, fifo_level);
        end
        for (int i = 0; i < DEPTH; i++) begin
            model_q.push_back('{addr: 32'h0FFC - 32'(i * 4), data: $urandom, strb: 4'hF});
            send_aw_w(model_q[i].addr, model_q[i].data, 4'hF, 0, 0, ok);
            wait_b(0, r, ok);
            total++;
            if (!ok || r !== 2'b00 || fifo_level !== 3'(i + 1)) begin
                bad++;
                $display("FAIL dec_in%0d got ok=%0d br=%b lvl=%0d exp 1 00 %0d", i, ok, r, fifo_level, i + 1);
            end
        end
        send_aw_w(32'h1100, 32'h2222_2222, 4'hF, 0, 0, ok);
        wait_b(0, r, ok);
        total++;
        if (!ok || r !== 2'b10 || fifo_level !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL dec_full got ok=%0d br=%b lvl=%0d exp 1 10 %0d", ok, r, fifo_level, DEPTH);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_fifo_full();
        test_b_stall();
        test_random();
        test_reset_mid();
`ifdef AXIW_ADDR_DECODE_ERR_EN
        test_decode();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
